// File: rtl/m_bus_bridge.sv
// Memory-stage bus bridge: decodes the M-stage address, runs one registered
// req/ack transaction to the selected slave and stalls the pipeline until it completes.
module m_bus_bridge #(
    parameter int SLAVES  = 6,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [31:0]          m_addr,
    input  logic [31:0]          m_wdata,
    input  logic [3:0]           m_byteen,
    input  logic                 m_load,
    input  logic                 m_store,
    input  logic                 m_exc,
    output logic [31:0]          m_rdata,
    output logic                 m_stall,
    output logic                 bus_err,
    output logic                 dev_req,
    output logic [SLAVES-1:0]    dev_sel,
    output logic [31:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    output logic [3:0]           dev_byteen,
    output logic                 dev_we,
    input  logic [SLAVES-1:0]    dev_ack,
    input  logic [32*SLAVES-1:0] dev_rdata
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic                req_q, req_d;
    logic [SLAVES-1:0]   sel_q, sel_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         hold_q, hold_d;
    logic                err_q, err_d;

    logic [SLAVES-1:0]   hitVec;
    logic                valid;
    logic [SLAVES-1:0]   ackSeen;
    logic [31:0]         ackData;

    // Inclusive full-width range compare; DM starts at address 0.
    always_comb begin
        hitVec    = '0;
        hitVec[0] = (m_addr <= 32'h0000_2FFF);
        hitVec[1] = (m_addr >= 32'h0000_7F00) && (m_addr <= 32'h0000_7F0B);
        hitVec[2] = (m_addr >= 32'h0000_7F30) && (m_addr <= 32'h0000_7F3F);
        hitVec[3] = (m_addr >= 32'h0000_7F50) && (m_addr <= 32'h0000_7F57);
        hitVec[4] = (m_addr >= 32'h0000_7F60) && (m_addr <= 32'h0000_7F67);
        hitVec[5] = (m_addr >= 32'h0000_7F68) && (m_addr <= 32'h0000_7F6B);
    end

    assign valid   = (m_load | (m_store & (|m_byteen))) & ~m_exc & $onehot(hitVec);
    assign ackSeen = dev_ack & sel_q;

    always_comb begin
        ackData = '0;
        for (int i = 0; i < SLAVES; i++) begin
            if (ackSeen[i]) begin
                ackData = ackData | dev_rdata[32*i +: 32];
            end
        end
    end

    // Next-state and pipeline-facing outputs; an ack beats a coincident timeout.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        sel_d   = sel_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        err_d   = err_q;
        m_stall = 1'b0;
        m_rdata = 32'h0;
        bus_err = 1'b0;
        case (state_q)
            IDLE: begin
                m_stall = valid & reset_n;
                if (valid) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    sel_d   = hitVec;
                    we_d    = m_store;
                    be_d    = m_store ? m_byteen : 4'h0;
                    addr_d  = {m_addr[31:2], 2'b00};
                    wdata_d = m_wdata;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            BUSY: begin
                m_stall = 1'b1;
                if (|ackSeen) begin
                    hold_d  = ackData;
                    state_d = DONE;
                    req_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    be_d    = 4'h0;
                end else if (cnt_q == CNT_LAST) begin
                    hold_d  = 32'h0;
                    err_d   = 1'b1;
                    state_d = DONE;
                    req_d   = 1'b0;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    be_d    = 4'h0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                m_rdata = hold_q;
                bus_err = err_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'h0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= '0;
            hold_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
        end
    end

    assign dev_req    = req_q;
    assign dev_sel    = sel_q;
    assign dev_we     = we_q;
    assign dev_byteen = be_q;
    assign dev_addr   = addr_q;
    assign dev_wdata  = wdata_q;

endmodule

// File: tb/tb_m_bus_bridge.sv
// Self-checking bench for m_bus_bridge: scripted slave acks with a queue of
// expected completions compared when the bridge reaches its DONE cycle.
module tb_m_bus_bridge;

    localparam int SLAVES = 6;

    logic                 clk;
    logic                 reset_n;
    logic [31:0]          mAddr;
    logic [31:0]          mWdata;
    logic [3:0]           mByteen;
    logic                 mLoad;
    logic                 mStore;
    logic                 mExc;
    logic [31:0]          mRdata;
    logic                 mStall;
    logic                 busErr;
    logic                 devReq;
    logic [SLAVES-1:0]    devSel;
    logic [31:0]          devAddr;
    logic [31:0]          devWdata;
    logic [3:0]           devByteen;
    logic                 devWe;
    logic [SLAVES-1:0]    devAck;
    logic [32*SLAVES-1:0] devRdata;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t expQ[$];

    m_bus_bridge #(.SLAVES(SLAVES), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .m_addr(mAddr), .m_wdata(mWdata), .m_byteen(mByteen),
        .m_load(mLoad), .m_store(mStore), .m_exc(mExc),
        .m_rdata(mRdata), .m_stall(mStall), .bus_err(busErr),
        .dev_req(devReq), .dev_sel(devSel), .dev_addr(devAddr),
        .dev_wdata(devWdata), .dev_byteen(devByteen), .dev_we(devWe),
        .dev_ack(devAck), .dev_rdata(devRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Fill every slave slice with a distinct filler, then place the real word.
    task automatic setRdata(input int slave, input logic [31:0] word);
        for (int i = 0; i < SLAVES; i++) devRdata[32*i +: 32] = 32'hA5A5_0000 | i;
        devRdata[32*slave +: 32] = word;
    endtask

    task automatic clearInputs();
        mAddr = 0; mWdata = 0; mByteen = 0; mLoad = 0; mStore = 0; mExc = 0; devAck = 0;
    endtask

    // Drives one access starting in the next cycle; ack lands on BUSY cycle ackOn (0 = never).
    task automatic doAccess(
        input logic [31:0] addr, input logic ld, input logic st, input logic [31:0] wd,
        input logic [3:0] be, input int ackOn, input int slave, input logic [31:0] word,
        input logic [5:0] stray,
        output int stalls, output logic [31:0] rdOut, output logic errOut,
        output logic [5:0] selOut, output logic weOut, output logic [31:0] addrOut,
        output logic [3:0] beOut, output bit stable, output bit done, output int doneCycle,
        output logic reqInDone);
        int busy;
        @(posedge clk); #1;
        mAddr = addr; mLoad = ld; mStore = st; mWdata = wd; mByteen = be; mExc = 0;
        setRdata(slave, word);
        devAck = 0;
        stalls = 0; busy = 0; stable = 1; done = 0;
        selOut = 0; weOut = 0; addrOut = 0; beOut = 0; rdOut = 0; errOut = 0;
        doneCycle = 0; reqInDone = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!mStall) begin
                done = 1;
                break;
            end
            stalls++;
            if (devReq) begin
                busy++;
                if (busy == 1) begin
                    selOut = devSel; weOut = devWe; addrOut = devAddr; beOut = devByteen;
                end else if (devSel !== selOut || devWe !== weOut || devAddr !== addrOut ||
                             devByteen !== beOut) begin
                    stable = 0;
                end
                if (ackOn != 0 && busy == ackOn) devAck = 6'b1 << slave;
                else                             devAck = stray;
            end
            @(posedge clk); #1;
        end
        devAck = 0;
        if (done) begin
            rdOut = mRdata; errOut = busErr; doneCycle = cycle; reqInDone = devReq;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({devReq, devSel, devWe, devByteen} !== 12'h0 || devAddr !== 0 || devWdata !== 0) begin
            failures++;
            $display("[TB] FAIL reset_dev got req=%b sel=%b addr=%h exp all zero", devReq, devSel, devAddr);
        end
        checks++;
        if ({mStall, busErr} !== 2'b00 || mRdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_m got stall=%b err=%b rdata=%h exp 0", mStall, busErr, mRdata);
        end
    endtask

    task automatic test_dm_load();
        int st; logic [31:0] rd; logic er; logic [5:0] sl; logic we; logic [31:0] ad;
        logic [3:0] be; bit stb; bit dn; int dc; logic rq; exp_t e;
        expQ.push_back('{32'hDEADBEEF, 1'b0});
        doAccess(32'h0000_1004, 1, 0, 32'h1234_5678, 4'h0, 1, 0, 32'hDEADBEEF, 6'h0,
                 st, rd, er, sl, we, ad, be, stb, dn, dc, rq);
        e = expQ.pop_front();
        checks++;
        if (!dn) begin failures++; $display("[TB] FAIL dm_done got none exp completion"); end
        checks++;
        if (sl !== 6'b000001 || ad !== 32'h1004 || be !== 4'h0 || we !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dm_req got sel=%b addr=%h be=%h we=%b exp 000001/1004/0/0", sl, ad, be, we);
        end
        checks++;
        if (st !== 2) begin failures++; $display("[TB] FAIL dm_stall got %0d exp 2", st); end
        checks++;
        if (rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("[TB] FAIL dm_rdata got %h/%b exp %h/%b", rd, er, e.rdata, e.err);
        end
        checks++;
        if (rq !== 1'b0) begin failures++; $display("[TB] FAIL dm_req_done got %b exp 0", rq); end
        clearInputs();
        @(posedge clk); #2;
        checks++;
        if (mRdata !== 32'h0 || mStall !== 1'b0 || devReq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dm_idle got rdata=%h stall=%b req=%b exp 0", mRdata, mStall, devReq);
        end
    endtask

    task automatic test_uart_store();
        int st; logic [31:0] rd; logic er; logic [5:0] sl; logic we; logic [31:0] ad;
        logic [3:0] be; bit stb; bit dn; int dc; logic rq; exp_t e;
        expQ.push_back('{32'h0000_0055, 1'b0});
        doAccess(32'h0000_7F30, 0, 1, 32'h41, 4'hF, 5, 2, 32'h0000_0055, 6'h0,
                 st, rd, er, sl, we, ad, be, stb, dn, dc, rq);
        e = expQ.pop_front();
        checks++;
        if (sl !== 6'b000100 || we !== 1'b1 || be !== 4'hF || ad !== 32'h7F30 || !stb) begin
            failures++;
            $display("[TB] FAIL uart_req got sel=%b we=%b be=%h addr=%h stable=%0d exp 000100/1/F/7F30/1",
                     sl, we, be, ad, stb);
        end
        checks++;
        if (st !== 6) begin failures++; $display("[TB] FAIL uart_stall got %0d exp 6", st); end
        checks++;
        if (!dn || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("[TB] FAIL uart_done got %h/%b done=%0d exp %h/%b", rd, er, dn, e.rdata, e.err);
        end
        clearInputs();
    endtask

    task automatic test_no_access();
        logic [31:0] addrs [6] = '{32'h0000_4000, 32'h0000_1000, 32'h0000_1000,
                                   32'h0001_1004, 32'h0000_3000, 32'h0000_7F0C};
        logic [2:0] mode [6] = '{3'b100, 3'b101, 3'b010, 3'b100, 3'b100, 3'b100};
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            mAddr = addrs[i]; mLoad = mode[i][2]; mStore = mode[i][1]; mExc = mode[i][0];
            mByteen = 4'h0; mWdata = 32'hFFFF_FFFF;
            #1;
            checks++;
            if (mStall !== 1'b0 || mRdata !== 32'h0) begin
                failures++;
                $display("[TB] FAIL noacc_comb[%0d] got stall=%b rdata=%h exp 0/0", i, mStall, mRdata);
            end
            @(posedge clk); #2;
            checks++;
            if (devReq !== 1'b0 || mStall !== 1'b0) begin
                failures++;
                $display("[TB] FAIL noacc_req[%0d] got req=%b stall=%b exp 0/0", i, devReq, mStall);
            end
        end
        clearInputs();
    endtask

    task automatic test_timeout();
        int st; logic [31:0] rd; logic er; logic [5:0] sl; logic we; logic [31:0] ad;
        logic [3:0] be; bit stb; bit dn; int dc; logic rq; exp_t e;
        expQ.push_back('{32'h0, 1'b1});
        doAccess(32'h0000_7F68, 1, 0, 0, 4'h0, 0, 5, 32'h7777_7777, 6'h0,
                 st, rd, er, sl, we, ad, be, stb, dn, dc, rq);
        e = expQ.pop_front();
        checks++;
        if (st !== 9 || sl !== 6'b100000) begin
            failures++;
            $display("[TB] FAIL tmo_stall got stalls=%0d sel=%b exp 9/100000", st, sl);
        end
        checks++;
        if (!dn || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("[TB] FAIL tmo_done got %h/%b exp %h/%b", rd, er, e.rdata, e.err);
        end
        clearInputs();
        @(posedge clk); #2;
        checks++;
        if (busErr !== 1'b0) begin failures++; $display("[TB] FAIL tmo_pulse got %b exp 0", busErr); end

        expQ.push_back('{32'h0BAD_CAFE, 1'b0});
        doAccess(32'h0000_7F68, 1, 0, 0, 4'h0, 8, 5, 32'h0BAD_CAFE, 6'h0,
                 st, rd, er, sl, we, ad, be, stb, dn, dc, rq);
        e = expQ.pop_front();
        checks++;
        if (st !== 9 || !dn || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("[TB] FAIL tmo_lateack got stalls=%0d %h/%b exp 9 %h/%b", st, rd, er, e.rdata, e.err);
        end
        clearInputs();
    endtask

    task automatic test_stray_ack();
        int st; logic [31:0] rd; logic er; logic [5:0] sl; logic we; logic [31:0] ad;
        logic [3:0] be; bit stb; bit dn; int dc; logic rq; exp_t e;
        expQ.push_back('{32'h1357_9BDF, 1'b0});
        doAccess(32'h0000_0008, 1, 0, 0, 4'h0, 4, 0, 32'h1357_9BDF, 6'b000010,
                 st, rd, er, sl, we, ad, be, stb, dn, dc, rq);
        e = expQ.pop_front();
        checks++;
        if (st !== 5 || !dn || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("[TB] FAIL stray got stalls=%0d %h/%b exp 5 %h/%b", st, rd, er, e.rdata, e.err);
        end
        clearInputs();
    endtask

    task automatic test_back_to_back();
        int st1, st2, dc1, dc2; logic [31:0] rd; logic er; logic [5:0] sl; logic we;
        logic [31:0] ad; logic [3:0] be; bit stb; bit dn1, dn2; logic rq; exp_t e;
        expQ.push_back('{32'h1111_2222, 1'b0});
        expQ.push_back('{32'hCAFE_F00D, 1'b0});
        doAccess(32'h0000_0100, 1, 0, 0, 4'h0, 1, 0, 32'h1111_2222, 6'h0,
                 st1, rd, er, sl, we, ad, be, stb, dn1, dc1, rq);
        e = expQ.pop_front();
        checks++;
        if (rd !== e.rdata || rq !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_first got %h req=%b exp %h req=0", rd, rq, e.rdata);
        end
        doAccess(32'h0000_2FFC, 1, 0, 0, 4'h0, 1, 0, 32'hCAFE_F00D, 6'h0,
                 st2, rd, er, sl, we, ad, be, stb, dn2, dc2, rq);
        e = expQ.pop_front();
        checks++;
        if (rd !== e.rdata || ad !== 32'h2FFC || st2 !== 2) begin
            failures++;
            $display("[TB] FAIL b2b_second got %h addr=%h stalls=%0d exp %h/2FFC/2", rd, ad, st2, e.rdata);
        end
        checks++;
        if (!dn1 || !dn2 || dc2 - dc1 !== 3) begin
            failures++;
            $display("[TB] FAIL b2b_gap got %0d cycles exp 3", dc2 - dc1);
        end
        clearInputs();
    endtask

    task automatic test_reset_mid_busy();
        int st; logic [31:0] rd; logic er; logic [5:0] sl; logic we; logic [31:0] ad;
        logic [3:0] be; bit stb; bit dn; int dc; logic rq; exp_t e;
        @(posedge clk); #1;
        mAddr = 32'h0000_0200; mLoad = 1;
        setRdata(0, 32'h9999_9999);
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (devReq !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_busy got req=%b exp 1", devReq); end
        reset_n = 0;
        #1;
        checks++;
        if ({devReq, devSel, devWe, devByteen, mStall, busErr} !== 14'h0 || devAddr !== 0 || mRdata !== 0) begin
            failures++;
            $display("[TB] FAIL rstmid_clear got req=%b sel=%b stall=%b addr=%h exp 0", devReq, devSel, mStall, devAddr);
        end
        clearInputs();
        @(posedge clk); #1;
        reset_n = 1;
        expQ.push_back('{32'h0F0F_0F0F, 1'b0});
        doAccess(32'h0000_7F00, 1, 0, 0, 4'h0, 1, 1, 32'h0F0F_0F0F, 6'h0,
                 st, rd, er, sl, we, ad, be, stb, dn, dc, rq);
        e = expQ.pop_front();
        checks++;
        if (sl !== 6'b000010 || st !== 2 || !dn || rd !== e.rdata || er !== e.err) begin
            failures++;
            $display("[TB] FAIL rstmid_new got sel=%b stalls=%0d %h/%b exp 000010/2 %h/%b",
                     sl, st, rd, er, e.rdata, e.err);
        end
        clearInputs();
    endtask

    initial begin
        reset_n = 0;
        devRdata = '0;
        clearInputs();
        #22;
        test_reset();
        @(posedge clk); #1;
        reset_n = 1;
        test_dm_load();
        test_uart_store();
        test_no_access();
        test_timeout();
        test_stray_ack();
        test_back_to_back();
        test_reset_mid_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
